// File: rtl/ldpc_ber_tester_dec_emu.sv
// Behavioural LDPC decoder stand-in for the BER tester. It hard-slices the
// incoming LLR beats, packs eight 16-bit slices into one 128-bit output beat,
// counts zero-valued LLRs and reports one status word per block.
module ldpc_ber_tester_dec_emu #(
  parameter int ITER_COUNT     = 4,
  parameter int FAIL_THRESHOLD = 0,
  parameter int LATENCY        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_axis_ctrl_tdata,
  input  logic         s_axis_ctrl_tvalid,
  output logic         s_axis_ctrl_tready,
  input  logic [127:0] s_axis_din_tdata,
  input  logic         s_axis_din_tvalid,
  output logic         s_axis_din_tready,
  input  logic         s_axis_din_tlast,
  output logic [127:0] m_axis_dout_tdata,
  output logic         m_axis_dout_tvalid,
  input  logic         m_axis_dout_tready,
  output logic         m_axis_dout_tlast,
  output logic [31:0]  m_axis_status_tdata,
  output logic         m_axis_status_tvalid,
  input  logic         m_axis_status_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_STAT
  } state_t;

  // Last value of the latency counter; LATENCY = 0 still spends one cycle in WAIT.
  localparam logic [15:0] WAIT_LAST = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;

  state_t         state_q, state_d;
  logic [7:0]     id_q;
  logic [15:0]    zero_cnt_q;
  logic [2:0]     slot_q;
  logic [15:0]    wait_cnt_q;
  logic [127:0]   acc_q;
  logic [127:0]   dout_data_q;
  logic           dout_valid_q;
  logic           dout_last_q;

  logic           ctrl_fire, din_fire, dout_fire, status_fire;
  logic           wait_done, fail;
  logic [15:0]    slice;
  logic [4:0]     zero_pop;
  logic [16:0]    zero_sum;
  logic [15:0]    zero_next;
  logic [127:0]   placed;

  assign ctrl_fire   = s_axis_ctrl_tvalid && s_axis_ctrl_tready;
  assign din_fire    = s_axis_din_tvalid && s_axis_din_tready;
  assign dout_fire   = dout_valid_q && m_axis_dout_tready;
  assign status_fire = m_axis_status_tvalid && m_axis_status_tready;
  assign wait_done   = (wait_cnt_q == WAIT_LAST);
  assign fail        = ({16'd0, zero_cnt_q} > 32'(FAIL_THRESHOLD));

  // Hard decision (sign bit), zero-LLR popcount and placement of the slice into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    slice    = '0;
    zero_pop = '0;
    placed   = '0;
    for (int i = 0; i < 16; i++) begin
      slice[i] = s_axis_din_tdata[8*i+7];
      if (s_axis_din_tdata[8*i +: 8] == 8'd0) zero_pop = zero_pop + 5'd1;
    end
    placed[16*slot_q +: 16] = slice;
    zero_sum  = {1'b0, zero_cnt_q} + 17'(zero_pop);
    zero_next = zero_sum[16] ? 16'hFFFF : zero_sum[15:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_fire) state_d = S_WAIT;
      S_WAIT:  if (wait_done) state_d = S_RUN;
      S_RUN:   if (din_fire && s_axis_din_tlast) state_d = S_DRAIN;
      S_DRAIN: if (dout_fire) state_d = S_STAT;
      S_STAT:  if (status_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; ready is forced low while reset is asserted.
  always_comb begin
    s_axis_ctrl_tready   = (state_q == S_IDLE) && !rst;
    s_axis_din_tready    = (state_q == S_RUN) && (!dout_valid_q || m_axis_dout_tready);
    m_axis_status_tvalid = (state_q == S_STAT);
    m_axis_status_tdata  = '0;
    if (state_q == S_STAT)
      m_axis_status_tdata = {zero_cnt_q, 1'b0, fail, 6'(ITER_COUNT), id_q};
  end

  // Block context, packing accumulator and the one-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q         <= '0;
      zero_cnt_q   <= '0;
      slot_q       <= '0;
      wait_cnt_q   <= '0;
      acc_q        <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      if (ctrl_fire) begin
        id_q       <= s_axis_ctrl_tdata[7:0];
        zero_cnt_q <= '0;
        slot_q     <= '0;
        acc_q      <= '0;
        wait_cnt_q <= '0;
      end
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 16'd1;
      if (dout_fire) dout_valid_q <= 1'b0;
      if (din_fire) begin
        zero_cnt_q <= zero_next;
        if (slot_q == 3'd7 || s_axis_din_tlast) begin
          dout_data_q  <= acc_q | placed;
          dout_valid_q <= 1'b1;
          dout_last_q  <= s_axis_din_tlast;
          acc_q        <= '0;
          slot_q       <= '0;
        end else begin
          acc_q  <= acc_q | placed;
          slot_q <= slot_q + 3'd1;
        end
      end
    end
  end

  assign m_axis_dout_tdata  = dout_data_q;
  assign m_axis_dout_tvalid = dout_valid_q;
  assign m_axis_dout_tlast  = dout_last_q;

endmodule

// File: tb/tb_ldpc_ber_tester_dec_emu.sv
// Scoreboard bench for ldpc_ber_tester_dec_emu: a block-level model pushes the
// expected DOUT beats and STATUS word, a monitor pops and compares on handshakes.
module tb_ldpc_ber_tester_dec_emu;

  localparam int ITER      = 4;
  localparam int THRESHOLD = 0;
  localparam int TIMEOUT   = 5000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ctrl_tdata;
  logic         ctrl_tvalid;
  logic         ctrl_tready;
  logic [127:0] din_tdata;
  logic         din_tvalid;
  logic         din_tready;
  logic         din_tlast;
  logic [127:0] dout_tdata;
  logic         dout_tvalid;
  logic         dout_tready;
  logic         dout_tlast;
  logic [31:0]  status_tdata;
  logic         status_tvalid;
  logic         status_tready;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } dout_t;

  dout_t        exp_dout[$];
  logic [31:0]  exp_stat[$];
  logic [127:0] blk[$];

  int vectors     = 0;
  int miscompares = 0;
  int dout_mode   = 0;  // 0: always ready, 1: toggling, 2: random
  int stat_mode   = 0;  // 0: always ready, 1: random

  ldpc_ber_tester_dec_emu #(
    .ITER_COUNT(ITER), .FAIL_THRESHOLD(THRESHOLD), .LATENCY(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_ctrl_tdata(ctrl_tdata), .s_axis_ctrl_tvalid(ctrl_tvalid),
    .s_axis_ctrl_tready(ctrl_tready),
    .s_axis_din_tdata(din_tdata), .s_axis_din_tvalid(din_tvalid),
    .s_axis_din_tready(din_tready), .s_axis_din_tlast(din_tlast),
    .m_axis_dout_tdata(dout_tdata), .m_axis_dout_tvalid(dout_tvalid),
    .m_axis_dout_tready(dout_tready), .m_axis_dout_tlast(dout_tlast),
    .m_axis_status_tdata(status_tdata), .m_axis_status_tvalid(status_tvalid),
    .m_axis_status_tready(status_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic abort(input string name);
    miscompares++;
    vectors++;
    $display("FAIL %s: timed out at %0t", name, $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Sink readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      dout_tready   = 1'b0;
      status_tready = 1'b0;
    end else begin
      case (dout_mode)
        0:       dout_tready = 1'b1;
        1:       dout_tready = ~dout_tready;
        default: dout_tready = 1'($urandom_range(0, 1));
      endcase
      status_tready = (stat_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares on handshakes, checks exclusivity, back-pressure and hold stability.
  logic         prev_dstall = 1'b0;
  logic [128:0] prev_d;
  logic         prev_sstall = 1'b0;
  logic [31:0]  prev_s;
  always @(negedge clk) begin
    if (rst) begin
      prev_dstall = 1'b0;
      prev_sstall = 1'b0;
    end else begin
      if (dout_tvalid && status_tvalid)
        check("dout_status_exclusive", 160'(1'b1), 160'(1'b0));
      if (prev_dstall)
        check("dout_hold_stable", 160'({dout_tvalid, dout_tlast, dout_tdata}), 160'({1'b1, prev_d}));
      if (prev_sstall)
        check("status_hold_stable", 160'({status_tvalid, status_tdata}), 160'({1'b1, prev_s}));
      if (dout_tvalid && !dout_tready)
        check("din_ready_while_held", 160'(din_tready), 160'(1'b0));
      if (dout_tvalid && dout_tready) begin
        if (exp_dout.size() == 0) begin
          check("unexpected_dout", 160'(1'b1), 160'(1'b0));
        end else begin
          dout_t e;
          e = exp_dout.pop_front();
          check("dout_tdata", 160'(dout_tdata), 160'(e.data));
          check("dout_tlast", 160'(dout_tlast), 160'(e.last));
        end
      end
      if (status_tvalid && status_tready) begin
        if (exp_stat.size() == 0) begin
          check("unexpected_status", 160'(1'b1), 160'(1'b0));
        end else begin
          logic [31:0] s;
          s = exp_stat.pop_front();
          check("status_tdata", 160'(status_tdata), 160'(s));
        end
      end
      prev_dstall = dout_tvalid && !dout_tready;
      prev_d      = {dout_tlast, dout_tdata};
      prev_sstall = status_tvalid && !status_tready;
      prev_s      = status_tdata;
    end
  end

  // Block-level reference: sign bits packed 8 beats per word, zero LLRs counted and saturated.
  task automatic model_block(input logic [7:0] id);
    int           zeros = 0;
    int           fill  = 0;
    logic [127:0] word  = '0;
    dout_t        e;
    logic [31:0]  s;
    for (int b = 0; b < blk.size(); b++) begin
      logic [127:0] w;
      w = blk[b];
      for (int i = 0; i < 16; i++) begin
        byte llr;
        llr = w[8*i +: 8];
        if (llr < 0) word[16*fill + i] = 1'b1;
        if (llr == 0) zeros++;
      end
      fill++;
      if (fill == 8 || b == blk.size() - 1) begin
        e.data = word;
        e.last = (b == blk.size() - 1);
        exp_dout.push_back(e);
        word = '0;
        fill = 0;
      end
    end
    if (zeros > 65535) zeros = 65535;
    s = {16'(zeros), 1'b0, (zeros > THRESHOLD), 6'(ITER), id};
    exp_stat.push_back(s);
  endtask

  task automatic send_ctrl(input logic [7:0] id);
    int n = 0;
    ctrl_tvalid = 1'b1;
    ctrl_tdata  = {24'($urandom), id};
    do begin
      @(negedge clk);
      n++;
    end while (!ctrl_tready && n < TIMEOUT);
    if (!ctrl_tready) abort("ctrl_handshake");
    @(posedge clk);
    #1;
    ctrl_tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] data, input logic last, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      din_tvalid = 1'b0;
      din_tdata  = {4{$urandom}};
      din_tlast  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    din_tvalid = 1'b1;
    din_tdata  = data;
    din_tlast  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!din_tready && n < TIMEOUT);
    if (!din_tready) abort("din_handshake");
    @(posedge clk);
    #1;
    din_tvalid = 1'b0;
    din_tlast  = 1'b0;
  endtask

  task automatic run_block(input logic [7:0] id, input bit gaps);
    model_block(id);
    send_ctrl(id);
    for (int b = 0; b < blk.size(); b++) send_beat(blk[b], (b == blk.size() - 1), gaps);
  endtask

  function automatic logic [127:0] rand_beat();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      w[8*i +: 8] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
    return w;
  endfunction

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_dout.size() != 0 || exp_stat.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_dout_left"}, 160'(exp_dout.size()), 160'(0));
    check({name, "_status_left"}, 160'(exp_stat.size()), 160'(0));
  endtask

  initial begin
    logic [127:0] w;
    rst         = 1'b1;
    ctrl_tdata  = '0;
    ctrl_tvalid = 1'b0;
    din_tdata   = '0;
    din_tvalid  = 1'b0;
    din_tlast   = 1'b0;
    #12;
    check("rst_ctrl_tready", 160'(ctrl_tready), 160'(1'b0));
    check("rst_din_tready", 160'(din_tready), 160'(1'b0));
    check("rst_dout_tvalid", 160'(dout_tvalid), 160'(1'b0));
    check("rst_dout_tdata", 160'({dout_tlast, dout_tdata}), 160'(0));
    check("rst_status", 160'({status_tvalid, status_tdata}), 160'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_ctrl_tready", 160'(ctrl_tready), 160'(1'b1));

    // 1: eight all-negative beats
    blk.delete();
    for (int b = 0; b < 8; b++) blk.push_back({16{8'hFD}});
    run_block(8'h5A, 1'b0);

    // 2: three beats +1, -1, +1
    blk.delete();
    blk.push_back({16{8'h01}});
    blk.push_back({16{8'hFF}});
    blk.push_back({16{8'h01}});
    run_block(8'h21, 1'b0);

    // 3: seventeen beats with toggling downstream ready
    dout_mode = 1;
    blk.delete();
    for (int b = 0; b < 17; b++) blk.push_back(rand_beat());
    run_block(8'h33, 1'b0);
    wait_drained("toggle");

    // 4: one beat with four zero LLRs, then saturation with 4096 all-zero beats
    dout_mode = 0;
    blk.delete();
    w = {16{8'h10}};
    w[7:0] = 8'd0; w[47:40] = 8'd0; w[79:72] = 8'd0; w[127:120] = 8'd0;
    blk.push_back(w);
    run_block(8'h44, 1'b1);
    blk.delete();
    for (int b = 0; b < 4096; b++) blk.push_back('0);
    run_block(8'hE7, 1'b0);
    wait_drained("saturate");

    // 5: reset during RUN after five beats; nothing from that block may appear
    send_ctrl(8'h99);
    for (int b = 0; b < 5; b++) send_beat(rand_beat(), 1'b0, 1'b0);
    din_tvalid = 1'b1;
    din_tdata  = rand_beat();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_dout_tvalid", 160'(dout_tvalid), 160'(1'b0));
    check("midrst_status_tvalid", 160'(status_tvalid), 160'(1'b0));
    check("midrst_din_tready", 160'(din_tready), 160'(1'b0));
    check("midrst_ctrl_tready", 160'(ctrl_tready), 160'(1'b0));
    din_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("postrst_idle", 160'(ctrl_tready), 160'(1'b1));
    repeat (20) @(posedge clk);
    #1;
    blk.delete();
    for (int b = 0; b < 10; b++) blk.push_back(rand_beat());
    run_block(8'h5B, 1'b1);

    // Random blocks with random back-pressure and input gaps
    for (int k = 0; k < 8; k++) begin
      dout_mode = $urandom_range(0, 2);
      stat_mode = $urandom_range(0, 1);
      blk.delete();
      for (int b = 0, n = $urandom_range(1, 20); b < n; b++) blk.push_back(rand_beat());
      run_block(8'($urandom), 1'b1);
    end
    wait_drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
